uart_tx_arbiter: RTL

//  Shares one 8-bit-bus UART transmitter among NREQ byte-stream requesters, e.g. CPU console and debug monitor.

---
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among byte-stream requesters
// Polls the UART status register and writes the data register only when the holding register is empty.
module uart_tx_arbiter #(
  parameter int NREQ         = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     lock_tmo,
  input  logic [7:0]               uart_dbr,
  output logic [7:0]               uart_dbw,
  output logic                     uart_addr,
  output logic                     uart_we
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_ARB, S_POLL, S_CHECK, S_WRITE, S_LOCK} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_rr;
  logic [IW-1:0] r_grant;
  logic [7:0]    r_byte;
  logic          r_last;
  logic [TW-1:0] r_timer;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_sel;
  logic          w_found;
  logic          w_accept;
  logic          w_tmo;
  logic          w_unused_dbr;

  // Only the holding-register-full flag of the status word matters.
  assign w_unused_dbr = ^uart_dbr[6:0];

  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(r_rr) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    w_accept  = 1'b0;
    w_sel     = r_grant;
    w_tmo     = 1'b0;
    uart_addr = 1'b1;
    uart_we   = 1'b0;
    uart_dbw  = 8'h00;
    unique case (r_state)
      S_ARB: begin
        if (w_found) begin
          w_accept = 1'b1;
          w_sel    = w_win;
          w_next   = S_POLL;
        end
      end
      S_POLL:  w_next = S_CHECK;
      S_CHECK: if (!uart_dbr[7]) w_next = S_WRITE;
      S_WRITE: begin
        uart_addr = 1'b0;
        uart_we   = 1'b1;
        uart_dbw  = r_byte;
        w_next    = (r_last || LOCK_TIMEOUT == 0) ? S_ARB : S_LOCK;
      end
      S_LOCK: begin
        if (req_valid[r_grant]) begin
          w_accept = 1'b1;
          w_next   = S_POLL;
        end else if (r_timer == TW'(LOCK_TIMEOUT - 1)) begin
          w_tmo  = 1'b1;
          w_next = S_ARB;
        end
      end
      default: w_next = S_ARB;
    endcase
    // Handshake is suppressed while reset is held so nothing is consumed and dropped.
    if (w_accept && rst_n) req_ready[w_sel] = 1'b1;
  end

  assign lock_tmo = w_tmo;
  assign busy     = (r_state != S_ARB);
  assign grant_id = r_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ARB;
      r_rr    <= IW'(NREQ - 1);
      r_grant <= '0;
      r_byte  <= 8'h00;
      r_last  <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_byte <= req_data[8*w_sel +: 8];
        r_last <= req_last[w_sel];
      end
      if (r_state == S_ARB && w_found) begin
        r_rr    <= w_win;
        r_grant <= w_win;
      end
      if (r_state == S_WRITE || w_accept) begin
        r_timer <= '0;
      end else if (r_state == S_LOCK && !w_tmo) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

endmodule
